led_phy_tx: RTL and testbench

//  Serial LED line driver. Sits directly downstream of the 12-bit pixel FIFO that the zone FSM fills.
//  On send_start it drains LED_NUM RGB444 words from the FIFO.

---
 rtl/led_phy_tx.sv | 157 +++++++++++++++
 tb/tb_led_phy_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_phy_tx.sv
// WS2812-style serial LED driver: drains LED_NUM RGB444 words from the pixel FIFO,
// expands each to GRB888 and shifts it out MSB-first as NRZ pulses, then holds a latch gap.
module led_phy_tx #(
  parameter int LED_NUM  = 36,
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TBIT_CYC = 63,
  parameter int TRST_CYC = 15000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        send_start,
  input  logic        fifo_empty,
  input  logic [11:0] fifo_rdata,
  output logic        fifo_re,
  output logic        led_dout,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int TMR_W = $clog2(TBIT_CYC - 1) + 1;
  localparam int LED_W = $clog2(LED_NUM - 1) + 1;
  localparam int GAP_W = $clog2(TRST_CYC - 1) + 1;
  localparam int BIT_W = $clog2(23) + 1;

  localparam logic [TMR_W-1:0] TBIT_LAST = TMR_W'(TBIT_CYC - 1);
  localparam logic [TMR_W-1:0] T0H_LIM   = TMR_W'(T0H_CYC);
  localparam logic [TMR_W-1:0] T1H_LIM   = TMR_W'(T1H_CYC);
  localparam logic [LED_W-1:0] LED_LAST  = LED_W'(LED_NUM - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TRST_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(23);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_BIT,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [LED_W-1:0]   led_cnt_q, led_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]   bit_tmr_q, bit_tmr_d;
  logic [GAP_W-1:0]   gap_tmr_q, gap_tmr_d;
  logic [23:0]        sr_q, sr_d;
  logic               led_dout_q, led_dout_d;
  logic               done_q, done_d;
  logic               underrun_q, underrun_d;

  always_comb begin
    state_d    = state_q;
    led_cnt_d  = led_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_tmr_d  = bit_tmr_q;
    gap_tmr_d  = gap_tmr_q;
    sr_d       = sr_q;
    underrun_d = underrun_q;
    led_dout_d = 1'b0;
    done_d     = 1'b0;
    fifo_re    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (send_start) begin
          underrun_d = 1'b0;
          led_cnt_d  = '0;
          state_d    = S_FETCH;
        end
      end

      // An empty FIFO truncates the frame rather than stalling the line.
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_re = 1'b1;
          state_d = S_LOAD;
        end else begin
          underrun_d = 1'b1;
          gap_tmr_d  = '0;
          state_d    = S_GAP;
        end
      end

      // Each nibble is doubled ({n,n} == n*17) so full scale maps to 8'hFF.
      S_LOAD: begin
        sr_d      = {fifo_rdata[7:4],  fifo_rdata[7:4],
                     fifo_rdata[11:8], fifo_rdata[11:8],
                     fifo_rdata[3:0],  fifo_rdata[3:0]};
        bit_cnt_d = '0;
        bit_tmr_d = '0;
        state_d   = S_BIT;
      end

      S_BIT: begin
        led_dout_d = (bit_tmr_q < (sr_q[23] ? T1H_LIM : T0H_LIM));
        if (bit_tmr_q == TBIT_LAST) begin
          bit_tmr_d = '0;
          if (bit_cnt_q != BIT_LAST) begin
            sr_d      = {sr_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (led_cnt_q != LED_LAST) begin
            led_cnt_d = led_cnt_q + LED_W'(1);
            state_d   = S_FETCH;
          end else begin
            gap_tmr_d = '0;
            state_d   = S_GAP;
          end
        end else begin
          bit_tmr_d = bit_tmr_q + TMR_W'(1);
        end
      end

      S_GAP: begin
        if (gap_tmr_q == GAP_LAST) begin
          gap_tmr_d = '0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          gap_tmr_d = gap_tmr_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      led_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bit_tmr_q  <= '0;
      gap_tmr_q  <= '0;
      sr_q       <= '0;
      led_dout_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_cnt_q  <= led_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_tmr_q  <= bit_tmr_d;
      gap_tmr_q  <= gap_tmr_d;
      sr_q       <= sr_d;
      led_dout_q <= led_dout_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign led_dout = led_dout_q;
  assign done     = done_q;
  assign underrun = underrun_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_phy_tx.sv
// Scoreboard bench for led_phy_tx: a waveform monitor decodes led_dout into GRB words and
// frame events, compared against expectations computed from the pixel words pushed into a FIFO model.
module tb_led_phy_tx;

  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int TRST = 10;
  localparam int NLED = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        send_start = 1'b0;
  logic        fifo_empty;
  logic [11:0] fifo_rdata = '0;
  logic        fifo_re, led_dout, busy, done, underrun;

  always #5 clk = ~clk;

  led_phy_tx #(
    .LED_NUM (NLED),
    .T0H_CYC (T0H),
    .T1H_CYC (T1H),
    .TBIT_CYC(TBIT),
    .TRST_CYC(TRST)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .send_start(send_start),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_re   (fifo_re),
    .led_dout  (led_dout),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  // Pixel FIFO model: data appears the cycle after a read enable.
  logic [11:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_re && (wr_ptr != rd_ptr)) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  typedef struct {
    int nwords;
    bit urun;
  } frame_t;

  logic [11:0] model_q [$];
  logic [23:0] exp_words [$];
  frame_t      exp_frames [$];

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] expandGrb(input logic [11:0] w);
    int r = w[11:8] * 17;
    int g = w[7:4] * 17;
    int b = w[3:0] * 17;
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  // Monitor: decode high-pulse widths into bits, assemble 24-bit words, close frames on done.
  bit          prev_led = 0;
  bit          prev_done = 0;
  int          run_hi = 0, run_lo = 0, since_rise = 0, last_h = 0;
  int          nbits = 0, frame_bits = 0, words_seen = 0, re_cnt = 0;
  logic [23:0] cur_word = '0;

  always @(negedge clk) begin : monitor
    logic [23:0] exp_w;
    frame_t      f;
    int          exp_p;
    int          exp_low;
    if (!rstn) begin
      prev_led = 0; prev_done = 0; run_hi = 0; run_lo = 0; since_rise = 0;
      nbits = 0; frame_bits = 0; words_seen = 0; re_cnt = 0; cur_word = '0;
    end else begin
      if (fifo_re) begin
        re_cnt++;
        checkOutput(!fifo_empty, "re_while_empty", int'(fifo_empty), 0);
      end
      if (led_dout) begin
        if (!prev_led) begin
          if (frame_bits > 0) begin
            exp_p = (nbits == 0) ? TBIT + 2 : TBIT;
            checkOutput(since_rise == exp_p, "bit_period", since_rise, exp_p);
          end
          since_rise = 0;
          run_hi = 0;
        end
        run_hi++;
      end else begin
        if (prev_led) begin
          checkOutput(run_hi == T0H || run_hi == T1H, "pulse_width", run_hi,
                      (run_hi > T0H) ? T1H : T0H);
          cur_word = {cur_word[22:0], (run_hi >= T1H)};
          last_h = run_hi;
          nbits++;
          frame_bits++;
          run_lo = 0;
          if (nbits == 24) begin
            nbits = 0;
            words_seen++;
            if (exp_words.size() == 0) begin
              checkOutput(1'b0, "unexpected_word", int'(cur_word), 0);
            end else begin
              exp_w = exp_words.pop_front();
              checkOutput(cur_word == exp_w, "word", int'(cur_word), int'(exp_w));
            end
          end
        end
        run_lo++;
      end
      since_rise++;
      if (done) begin
        checkOutput(!prev_done, "done_single", int'(prev_done), 0);
        if (!prev_done) begin
          if (exp_frames.size() == 0) begin
            checkOutput(1'b0, "unexpected_done", 1, 0);
          end else begin
            f = exp_frames.pop_front();
            checkOutput(busy == 1'b0, "busy_at_done", int'(busy), 0);
            checkOutput(underrun == f.urun, "underrun", int'(underrun), int'(f.urun));
            checkOutput(re_cnt == f.nwords, "fifo_re_count", re_cnt, f.nwords);
            checkOutput(words_seen == f.nwords && nbits == 0, "words_sent", words_seen, f.nwords);
            if (frame_bits > 0) begin
              exp_low = TBIT - last_h + TRST + (f.urun ? 1 : 0);
              checkOutput(run_lo == exp_low, "gap_low", run_lo, exp_low);
            end
          end
          re_cnt = 0;
          words_seen = 0;
          frame_bits = 0;
          nbits = 0;
        end
      end
      prev_led = led_dout;
      prev_done = done;
    end
  end

  task automatic pushWord(input logic [11:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
    model_q.push_back(w);
  endtask

  // Issue one send_start from IDLE and record what the frame must produce.
  task automatic applyStimulus();
    frame_t f;
    int     avail;
    @(negedge clk);
    avail = model_q.size();
    f.nwords = (avail < NLED) ? avail : NLED;
    f.urun = (avail < NLED);
    for (int i = 0; i < f.nwords; i++) exp_words.push_back(expandGrb(model_q.pop_front()));
    exp_frames.push_back(f);
    send_start = 1'b1;
    @(negedge clk);
    send_start = 1'b0;
    checkOutput(busy == 1'b1, "busy_after_start", int'(busy), 1);
    checkOutput(underrun == 1'b0, "underrun_cleared", int'(underrun), 0);
  endtask

  // Wait for done; optionally pulse a stray send_start while the frame is busy.
  task automatic waitDone(input int limit, input int glitch_at);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) break;
      send_start = (i == glitch_at) && busy;
    end
    send_start = 1'b0;
    checkOutput(i < limit, "done_timeout", i, limit);
  endtask

  task automatic midFrameReset();
    @(posedge clk);
    #2;
    checkOutput(busy == 1'b1, "busy_before_reset", int'(busy), 1);
    rstn = 1'b0;
    #1;
    checkOutput(led_dout == 1'b0, "reset_led_dout", int'(led_dout), 0);
    checkOutput(busy == 1'b0, "reset_busy", int'(busy), 0);
    exp_words.delete();
    exp_frames.delete();
    @(negedge clk);
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput(fifo_re == 1'b0, "rst_fifo_re", int'(fifo_re), 0);
    checkOutput(led_dout == 1'b0, "rst_led_dout", int'(led_dout), 0);
    checkOutput(busy == 1'b0, "rst_busy", int'(busy), 0);
    checkOutput(done == 1'b0, "rst_done", int'(done), 0);
    checkOutput(underrun == 1'b0, "rst_underrun", int'(underrun), 0);
    @(posedge clk);
    #2;
    rstn = 1'b1;

    $display("[TB] basic frame");
    pushWord(12'hF00); pushWord(12'h0F0);
    applyStimulus();
    waitDone(1000, -1);

    $display("[TB] mixed pattern word");
    pushWord(12'h5A3); pushWord(12'h1E7);
    applyStimulus();
    waitDone(1000, -1);

    $display("[TB] underrun with one word");
    pushWord(12'h3C9);
    applyStimulus();
    waitDone(1000, -1);

    $display("[TB] stray send_start mid-frame");
    pushWord(12'h8F1); pushWord(12'h27D);
    applyStimulus();
    waitDone(1000, 40);

    $display("[TB] back-to-back frames");
    pushWord(12'hC36); pushWord(12'h9B4); pushWord(12'hC36); pushWord(12'h9B4);
    applyStimulus();
    waitDone(1000, -1);
    applyStimulus();
    waitDone(1000, -1);

    $display("[TB] underrun cleared on next start");
    applyStimulus();
    waitDone(1000, -1);
    pushWord(12'h0FF); pushWord(12'hF0F);
    applyStimulus();
    waitDone(1000, -1);

    $display("[TB] reset mid-frame");
    pushWord(12'hABC);
    applyStimulus();
    repeat (8) @(negedge clk);
    midFrameReset();
    pushWord(12'h135); pushWord(12'hE42);
    applyStimulus();
    waitDone(1000, -1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 10; k++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++) pushWord(12'($urandom));
      applyStimulus();
      waitDone(1000, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 250)) : -1);
    end

    repeat (3) @(negedge clk);
    checkOutput(exp_frames.size() == 0, "frames_left", exp_frames.size(), 0);
    checkOutput(exp_words.size() == 0, "words_left", exp_words.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
